lvds_iq_tx: RTL and testbench
=============================

LVDS_IQ_TX -- requirements
Module: lvds_iq_tx

Interface
REQ-001 i_ddr_clk  input  1  modem LVDS clock; the single clock of the block; all state changes on its rising edge.
REQ-002 i_rst_b  input  1  reset; asynchronous, active-low.
REQ-003 i_tx_enable  input  1  1 = stream I/Q frames to the modem; 0 = finish the current frame, then go idle.
REQ-004 i_fifo_empty  input  1  TX FIFO empty flag, read side.
REQ-005 i_fifo_data  input  32  TX FIFO read data; valid on the cycle after o_fifo_pull, held until the next pull.
REQ-006 o_fifo_pull  output  1  one-cycle FIFO read strobe.
REQ-007 o_fifo_read_clk  output  1  FIFO read clock; equals i_ddr_clk.
REQ-008 o_ddr_data  output  2  DDR bit pair: [1] drives the rising-edge phase (D_OUT_0), [0] drives the falling-edge phase (D_OUT_1).
REQ-009 o_underrun  output  1  one-cycle pulse when a frame boundary finds no fetched word.
REQ-010 o_debug_state  output  2  current FSM state encoding.

Function
REQ-011 The frame SHALL be 32 bits, laid out {2'b10, I[12:0], I_ctrl, 2'b01, Q[12:0], Q_ctrl}, MSB first, 2 bits per clock, so one frame takes 16 cycles.
REQ-012 The block SHALL force bits [31:30] to 2'b10 and [15:14] to 2'b01 on every loaded word, whatever the FIFO content.
REQ-013 The FSM SHALL have four states: IDLE=0, FETCH=1, WAIT=2, TX=3.
REQ-014 IDLE: o_ddr_data=2'b00 and the phase counter is held at 0; i_tx_enable=1 moves the FSM to FETCH.
REQ-015 FETCH: if i_fifo_empty=0, assert o_fifo_pull and go to WAIT; else stay in FETCH with o_ddr_data=00 and no o_underrun; i_tx_enable=0 returns the FSM to IDLE.
REQ-016 WAIT: lasts one cycle; then load the shift register from i_fifo_data (sync forced), set phase=0 and enter TX.
REQ-017 TX: each cycle, o_ddr_data=shift[31:30] (registered); then shift left by 2 and increment the 4-bit phase.
REQ-018 TX: at phase 13, assert o_fifo_pull only when i_tx_enable=1 and i_fifo_empty=0, and record a have_word flag.
REQ-019 TX, phase 15, have_word=1: load i_fifo_data (sync forced) and wrap the phase to 0; the next frame follows with no gap.
REQ-020 TX, phase 15, have_word=0 and enable=1: load the zero frame 32'h8000_4000, pulse o_underrun and stay in TX.
REQ-021 TX, phase 15, enable=0: go to IDLE; the frame in flight always completes, and no FIFO word is pulled and lost.
REQ-022 Latency: first bit pair of the first frame appears 3 cycles after i_tx_enable is sampled high with a non-empty FIFO.
REQ-023 Simultaneous events: empty deasserting at phase 13 yields a pull in that same cycle; enable deasserting at phase 13 yields no pull and the frame completes.
REQ-024 Throughput: one frame per 16 cycles; o_fifo_pull SHALL never be asserted on two consecutive cycles.

Reset
REQ-025 Reset values: state=IDLE, phase=0, shift=0, have_word=0, o_ddr_data=00, o_fifo_pull=0, o_underrun=0.
REQ-026 Reset asserted mid-frame SHALL clear all state immediately; the frame is abandoned and no pull is issued.
REQ-027 After reset is released, streaming restarts only through the FETCH sequence.

Structure
REQ-028 Shared package lvds_iq_pkg holds: state encodings; sync constants I_SYNC=2'b10 and Q_SYNC=2'b01; ZERO_FRAME=32'h8000_4000; FRAME_PHASES=16.
REQ-029 No sub-module: counter, FSM and serializer stay inline; the FIFO is the external complex_fifo, read-clocked by o_fifo_read_clk.

Verification
REQ-030 Single word: FIFO holds 32'h3FFF_3FFF and enable=1 -> one pull; bit pairs 10,11,...,01,11,... form word 32'hBFFF_7FFF; zero frame follows with o_underrun=1 once.
REQ-031 Back-to-back: 4 words queued -> 64 contiguous cycles of data; pulls only at phases 13 and 15-gaps; no underrun.
REQ-032 Underrun: FIFO empty at phase 13 -> frame 32'h8000_4000 sent, o_underrun pulses at phase 15; a refill resumes data on the next boundary.
REQ-033 Disable: enable dropped at phase 5 -> remaining 10 pairs sent, no phase-13 pull, IDLE with o_ddr_data=00.
REQ-034 Reset: i_rst_b low at phase 8 -> outputs 0 asynchronously, state IDLE, FIFO level unchanged.
REQ-035 Sync forcing: FIFO word 32'h0000_0000 -> transmitted frame is 32'h8000_4000.

Source files
------------

// File: rtl/lvds_iq_tx_pkg.sv
// Shared definitions for the LVDS I/Q modem transmitter: FSM encodings,
// frame sync constants and the helper that stamps sync bits onto a word.
package lvds_iq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_TX    = 2'd3
    } tx_state_t;

    localparam logic [1:0]  I_SYNC       = 2'b10;
    localparam logic [1:0]  Q_SYNC       = 2'b01;
    localparam logic [31:0] ZERO_FRAME   = 32'h8000_4000;
    localparam int          FRAME_PHASES = 16;

    // Last bit-pair slot of a frame, and the slot where the next word is requested
    // so that its data is settled by the time the frame boundary arrives.
    localparam logic [3:0]  LAST_PHASE   = 4'(FRAME_PHASES - 1);
    localparam logic [3:0]  PULL_PHASE   = 4'(FRAME_PHASES - 3);

    // Overwrite the I and Q sync fields regardless of what the FIFO delivered.
    function automatic logic [31:0] force_sync(input logic [31:0] word);
        return {I_SYNC, word[29:16], Q_SYNC, word[13:0]};
    endfunction

endpackage

// File: rtl/lvds_iq_tx_if.sv
// Read-side connection between the transmitter and the external TX FIFO.
interface lvds_iq_tx_if;

    logic        i_fifo_empty;
    logic [31:0] i_fifo_data;
    logic        o_fifo_pull;
    logic        o_fifo_read_clk;

    // The transmitter is the reader and drives the strobe and read clock.
    modport master (
        input  i_fifo_empty,
        input  i_fifo_data,
        output o_fifo_pull,
        output o_fifo_read_clk
    );

    // The FIFO presents its flag and data and consumes the strobe.
    modport slave (
        output i_fifo_empty,
        output i_fifo_data,
        input  o_fifo_pull,
        input  o_fifo_read_clk
    );

endinterface

// File: rtl/lvds_iq_tx.sv
// LVDS I/Q transmitter: fetches 32-bit words from the TX FIFO, stamps the
// sync fields and serialises each frame MSB first, two bits per clock.
module lvds_iq_tx
    import lvds_iq_pkg::*;
(
    input  logic              i_ddr_clk,
    input  logic              i_rst_b,
    input  logic              i_tx_enable,
    lvds_iq_tx_if.master      fifo,
    output logic [1:0]        o_ddr_data,
    output logic              o_underrun,
    output logic [1:0]        o_debug_state
);

    tx_state_t   state;
    tx_state_t   state_next;
    logic [3:0]  phase;
    logic [31:0] shift;
    logic        have_word;
    logic [1:0]  ddr_q;
    logic        pull_now;
    logic        underrun_now;
    logic        frame_end;

    assign fifo.o_fifo_read_clk = i_ddr_clk;
    assign frame_end            = (state == ST_TX) && (phase == LAST_PHASE);

    // State register.
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision; a frame in flight always runs to its last phase.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_tx_enable) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (!i_tx_enable)            state_next = ST_IDLE;
                else if (!fifo.i_fifo_empty) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                state_next = ST_TX;
            end
            ST_TX: begin
                if (frame_end && !have_word && !i_tx_enable) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FIFO strobe and underrun flag; a pull is only issued while enabled so no word is stranded.
    always_comb begin
        pull_now     = 1'b0;
        underrun_now = 1'b0;
        case (state)
            ST_FETCH: begin
                pull_now = i_tx_enable && !fifo.i_fifo_empty;
            end
            ST_TX: begin
                pull_now     = (phase == PULL_PHASE) && i_tx_enable && !fifo.i_fifo_empty;
                underrun_now = frame_end && !have_word && i_tx_enable;
            end
            default: begin
                pull_now     = 1'b0;
                underrun_now = 1'b0;
            end
        endcase
    end

    // Serializer, phase counter and fetched-word tracking.
    always_ff @(posedge i_ddr_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            phase     <= '0;
            shift     <= '0;
            have_word <= 1'b0;
            ddr_q     <= 2'b00;
        end else begin
            case (state)
                ST_WAIT: begin
                    shift     <= force_sync(fifo.i_fifo_data);
                    phase     <= '0;
                    have_word <= 1'b0;
                    ddr_q     <= 2'b00;
                end
                ST_TX: begin
                    ddr_q <= shift[31:30];
                    if (frame_end) begin
                        phase     <= '0;
                        have_word <= 1'b0;
                        if (have_word)        shift <= force_sync(fifo.i_fifo_data);
                        else if (i_tx_enable) shift <= ZERO_FRAME;
                        else                  shift <= '0;
                    end else begin
                        shift <= {shift[29:0], 2'b00};
                        phase <= phase + 4'd1;
                        if (phase == PULL_PHASE) have_word <= pull_now;
                    end
                end
                default: begin
                    phase     <= '0;
                    have_word <= 1'b0;
                    ddr_q     <= 2'b00;
                end
            endcase
        end
    end

    assign fifo.o_fifo_pull = pull_now;
    assign o_underrun       = underrun_now;
    assign o_ddr_data       = ddr_q;
    assign o_debug_state    = state;

endmodule

// File: tb/tb_lvds_iq_tx.sv
// Scoreboard bench for lvds_iq_tx: a queue-based FIFO model feeds the DUT,
// expected frames are queued when a scenario is issued, and a monitor
// reassembles serialised frames and compares them as they complete.
module tb_lvds_iq_tx;
    import lvds_iq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        tx_enable;
    logic [1:0]  ddr_data;
    logic        underrun;
    logic [1:0]  debug_state;

    lvds_iq_tx_if fifo_bus();

    lvds_iq_tx dut (
        .i_ddr_clk     (clk),
        .i_rst_b       (rst_b),
        .i_tx_enable   (tx_enable),
        .fifo          (fifo_bus),
        .o_ddr_data    (ddr_data),
        .o_underrun    (underrun),
        .o_debug_state (debug_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          pull_cnt = 0;
    int          underrun_cnt = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] stim_words[$];
    int          frame_starts[$];
    logic        prev_pull = 1'b0;
    logic        collecting = 1'b0;
    int          npairs = 0;
    logic [31:0] frame_acc = '0;

    // Transmitted frame as the modem sees it: payload kept, sync fields fixed.
    function automatic logic [31:0] ref_frame(input logic [31:0] w);
        return (w & 32'h3FFF_3FFF) | 32'h8000_4000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Cycle counter used to place stimulus at exact frame phases.
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO read port: a pull on a clock edge presents the next word, held until the next pull.
    always @(posedge clk) begin
        if (fifo_bus.o_fifo_pull && fifo_q.size() > 0)
            fifo_bus.i_fifo_data <= fifo_q.pop_front();
    end

    // Empty flag follows the model occupancy, updated away from the active edge.
    always @(negedge clk) fifo_bus.i_fifo_empty = (fifo_q.size() == 0);

    // Monitor: reassemble frames from bit pairs and score them against the expected queue.
    always @(negedge clk) begin
        if (!rst_b) begin
            collecting = 1'b0;
            npairs     = 0;
            prev_pull  = 1'b0;
        end else begin
            if (fifo_bus.o_fifo_pull) begin
                checkOutput("pull_spacing", 32'(prev_pull), 32'd0);
                pull_cnt++;
            end
            prev_pull = fifo_bus.o_fifo_pull;
            if (!collecting && ddr_data != 2'b00) begin
                collecting = 1'b1;
                npairs     = 0;
                frame_acc  = '0;
                frame_starts.push_back(cyc);
            end
            if (collecting) begin
                frame_acc = {frame_acc[29:0], ddr_data};
                npairs++;
                if (npairs == 16) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("[TB] FAIL unexpected_frame: got 0x%08h, expected no frame", frame_acc);
                    end else begin
                        checkOutput("frame", frame_acc, exp_q.pop_front());
                    end
                    collecting = 1'b0;
                    npairs     = 0;
                end
            end
            if (underrun) begin
                underrun_cnt++;
                checkOutput("underrun_phase", 32'(npairs), 32'd15);
            end
        end
    end

    // One streaming episode: preload stim_words, enable, optionally refill at
    // phase 0 of frame r, drop enable at phase p of frame m, then audit.
    task automatic applyStimulus(input int m, input int p, input int r, input logic [31:0] refill_word);
        logic [31:0] model_q[$];
        int exp_pulls = 0;
        int exp_zero  = 0;
        int c0, drop_cyc, refill_cyc, pulls0, und0;
        logic done = 1'b0;

        model_q = stim_words;
        for (int k = 0; k <= m; k++) begin
            if (r >= 0 && k == r + 1) model_q.push_back(refill_word);
            if (model_q.size() > 0) begin
                exp_q.push_back(ref_frame(model_q.pop_front()));
                exp_pulls++;
            end else begin
                exp_q.push_back(32'h8000_4000);
                exp_zero++;
            end
        end
        if (r >= 0 && r + 1 > m) model_q.push_back(refill_word);

        pulls0 = pull_cnt;
        und0   = underrun_cnt;
        frame_starts.delete();
        @(posedge clk); #1;
        foreach (stim_words[i]) fifo_q.push_back(stim_words[i]);
        tx_enable  = 1'b1;
        c0         = cyc + 1;
        drop_cyc   = c0 + 2 + 16 * m + p;
        refill_cyc = (r >= 0) ? c0 + 2 + 16 * r : -1;
        for (int c = 0; c < 16 * m + 60 && !done; c++) begin
            @(posedge clk); #1;
            if (cyc == refill_cyc) fifo_q.push_back(refill_word);
            if (cyc == drop_cyc) tx_enable = 1'b0;
            if (cyc > drop_cyc && debug_state == ST_IDLE) done = 1'b1;
        end
        tx_enable = 1'b0;
        checkOutput("return_idle", 32'(done), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("frames_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        checkOutput("frame_count", 32'(frame_starts.size()), 32'(m + 1));
        checkOutput("first_pair_latency",
                    (frame_starts.size() > 0) ? 32'(frame_starts[0] - c0) : 32'hFFFF_FFFF, 32'd3);
        checkOutput("pull_count", 32'(pull_cnt - pulls0), 32'(exp_pulls));
        checkOutput("underrun_count", 32'(underrun_cnt - und0), 32'(exp_zero));
        checkOutput("fifo_level", 32'(fifo_q.size()), 32'(model_q.size()));
        checkOutput("idle_ddr", 32'(ddr_data), 32'd0);
        fifo_q.delete();
    endtask

    // Reset asserted at phase 8 of the second frame: outputs clear at once and nothing more is pulled.
    task automatic applyMidFrameReset();
        int c0, pulls0;
        logic reached = 1'b0;
        stim_words = '{$urandom, $urandom, $urandom};
        exp_q.push_back(ref_frame(stim_words[0]));
        pulls0 = pull_cnt;
        @(posedge clk); #1;
        foreach (stim_words[i]) fifo_q.push_back(stim_words[i]);
        tx_enable = 1'b1;
        c0 = cyc + 1;
        for (int c = 0; c < 80 && !reached; c++) begin
            @(posedge clk); #1;
            if (cyc == c0 + 2 + 16 + 8) reached = 1'b1;
        end
        checkOutput("reached_phase8", 32'(reached), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        checkOutput("rst_async_ddr", 32'(ddr_data), 32'd0);
        checkOutput("rst_async_pull", 32'(fifo_bus.o_fifo_pull), 32'd0);
        checkOutput("rst_async_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_async_state", 32'(debug_state), 32'(ST_IDLE));
        tx_enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_fifo_level", 32'(fifo_q.size()), 32'd1);
        checkOutput("rst_frames_pending", 32'(exp_q.size()), 32'd0);
        checkOutput("rst_pull_count", 32'(pull_cnt - pulls0), 32'd2);
        exp_q.delete();
        fifo_q.delete();
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("post_rst_state", 32'(debug_state), 32'(ST_IDLE));
    endtask

    // Directed corner cases first, then randomised episodes.
    initial begin
        int n, m, p, r;
        rst_b     = 1'b0;
        tx_enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ddr", 32'(ddr_data), 32'd0);
        checkOutput("reset_pull", 32'(fifo_bus.o_fifo_pull), 32'd0);
        checkOutput("reset_underrun", 32'(underrun), 32'd0);
        checkOutput("reset_state", 32'(debug_state), 32'(ST_IDLE));
        rst_b = 1'b1;
        repeat (2) @(posedge clk);

        $display("[TB] single word followed by a zero frame");
        stim_words = '{32'h3FFF_3FFF};
        applyStimulus(1, 7, -1, 32'h0);

        $display("[TB] all-zero word gets sync bits");
        stim_words = '{32'h0000_0000};
        applyStimulus(0, 4, -1, 32'h0);

        $display("[TB] four words back to back, enable dropped at phase 5");
        stim_words = '{$urandom, $urandom, $urandom, $urandom};
        applyStimulus(3, 5, -1, 32'h0);

        $display("[TB] underrun then refill");
        stim_words = '{$urandom};
        applyStimulus(3, 2, 1, $urandom);

        $display("[TB] enable dropped exactly at phase 13");
        stim_words = '{$urandom, $urandom};
        applyStimulus(0, 13, -1, 32'h0);

        $display("[TB] reset in the middle of a frame");
        applyMidFrameReset();

        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 4);
            m = $urandom_range(0, 5);
            p = $urandom_range(0, 13);
            r = ($urandom_range(0, 1) == 1) ? $urandom_range(0, m) : -1;
            stim_words.delete();
            for (int i = 0; i < n; i++) stim_words.push_back($urandom);
            $display("[TB] random episode %0d: words=%0d last_frame=%0d drop_phase=%0d refill=%0d", t, n, m, p, r);
            applyStimulus(m, p, r, $urandom);
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
